// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmitter with integrated FIFO.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count and registered read data updated on pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames run back-to-back with per-frame latched config.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic [1:0]                      cfg_parity,
    input  logic                            cfg_stop2,
    input  logic                            in_valid,
    input  logic [DATA_BITS-1:0]            in_data,
    output logic                            in_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int unsigned BIW = $clog2(DATA_BITS);

    state_t                 state_q;
    state_t                 state_d;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [DATA_BITS-1:0]   head;
    logic [DIV_W-1:0]       div_clamped;
    logic [DIV_W-1:0]       div_q;
    logic [1:0]             par_q;
    logic                   stop2_q;
    logic [DIV_W-1:0]       bit_cnt_q;
    logic [BIW-1:0]         bit_idx_q;
    logic                   stop_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q;
    logic                   tx_d;
    logic                   bit_end;
    logic                   last_data;
    logic                   last_stop;
    logic                   par_en;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid && in_ready),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign in_ready    = !rst && !full;
    assign busy        = (state_q != ST_IDLE) || (fifo_count != '0);
    assign div_clamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
    assign bit_end     = (bit_cnt_q == div_q - DIV_W'(1));
    assign last_data   = (bit_idx_q == BIW'(DATA_BITS - 1));
    assign last_stop   = stop_cnt_q || !stop2_q;
    assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // tx_d is the line level for the current state; the tx register delays it by one cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end && last_data) begin
                    state_d = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_d = par_bit_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end && last_stop) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            tx         <= 1'b1;
        end else begin
            tx <= tx_d;
            if (pop) begin
                div_q      <= div_clamped;
                par_q      <= cfg_parity;
                stop2_q    <= cfg_stop2;
                bit_cnt_q  <= '0;
                bit_idx_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (state_q != ST_IDLE) begin
                if (bit_end) begin
                    bit_cnt_q <= '0;
                    if (state_q == ST_DATA) begin
                        bit_idx_q <= last_data ? '0 : bit_idx_q + BIW'(1);
                    end
                    if (state_q == ST_STOP) begin
                        stop_cnt_q <= !last_stop;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + DIV_W'(1);
                end
            end
            // The popped word lands in head at the pop edge; parity is taken from it before shifting starts.
            if (state_q == ST_START && bit_end) begin
                shift_q   <= head;
                par_bit_q <= (^head) ^ (par_q == PAR_ODD);
            end else if (state_q == ST_DATA && bit_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

endmodule
